// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    localparam int unsigned OP_DIV_BIT      = 1;
    localparam int unsigned OP_UNSIGNED_BIT = 0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PREP = 2'd1;
    localparam logic [1:0] CALC = 2'd2;
    localparam logic [1:0] FIX  = 2'd3;

    function automatic logic op_is_div(input op_e o);
        return o[OP_DIV_BIT];
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return !o[OP_UNSIGNED_BIT];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply or restoring trial-subtract
// for divide, both sharing a single WIDTH+1-bit adder.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   add_y;
    logic             cin;
    logic [WIDTH+1:0] sum;

    always_comb begin
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        if (is_div) begin
            add_x = shifted;
            add_y = ~{1'b0, opnd};
            cin   = 1'b1;
        end else begin
            add_x = {1'b0, acc_hi};
            add_y = acc_lo[0] ? {1'b0, opnd} : '0;
            cin   = 1'b0;
        end
        sum = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+2)'(cin);

        // Divide: carry out of the subtract means no borrow, i.e. quotient bit 1
        if (is_div) begin
            hi_next = sum[WIDTH+1] ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
            lo_next = {acc_lo[WIDTH-2:0], sum[WIDTH+1]};
        end else begin
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit with HI/LO result registers.
// Optional MULDIV_EARLY_TERM_EN ends multiply once the remaining multiplier is zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    op_e              op_q;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             neg_lo;
    logic             neg_hi;
    logic [CNT_W-1:0] cnt;

    logic             is_div;
    logic             is_signed;
    logic             lo_neg;
    logic             opnd_neg;
    logic [WIDTH-1:0] mag_lo;
    logic [WIDTH-1:0] mag_opnd;
    logic             div_zero;
    logic             last_step;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;

`ifdef MULDIV_EARLY_TERM_EN
    logic [WIDTH-1:0] mplr;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .opnd    (opnd),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

    // Operand decode, magnitudes and result correction
    always_comb begin
        is_div    = op_is_div(op_q);
        is_signed = op_is_signed(op_q);
        lo_neg    = is_signed && acc_lo[WIDTH-1];
        opnd_neg  = is_signed && opnd[WIDTH-1];
        mag_lo    = lo_neg ? -acc_lo : acc_lo;
        mag_opnd  = opnd_neg ? -opnd : opnd;
        div_zero  = is_div && (opnd == '0);
`ifdef MULDIV_EARLY_TERM_EN
        last_step = (cnt == CNT_W'(WIDTH - 1)) || (!is_div && (mplr[WIDTH-1:1] == '0));
        prod_raw  = {acc_hi, acc_lo} >> (CNT_W'(WIDTH) - cnt);
`else
        last_step = (cnt == CNT_W'(WIDTH - 1));
        prod_raw  = {acc_hi, acc_lo};
`endif
        prod_fix  = neg_lo ? -prod_raw : prod_raw;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = PREP;
            PREP:    state_next = div_zero ? IDLE : CALC;
            CALC:    if (last_step) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q   <= OP_MULT;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef MULDIV_EARLY_TERM_EN
            mplr   <= '0;
`endif
        end else begin
            busy <= (state_next != IDLE);
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op_e'(op);
                        acc_lo <= a;
                        opnd   <= b;
                        div0   <= 1'b0;
                    end
                end
                PREP: begin
                    acc_hi <= '0;
                    cnt    <= '0;
                    neg_lo <= lo_neg ^ opnd_neg;
                    neg_hi <= lo_neg;
`ifdef MULDIV_EARLY_TERM_EN
                    mplr   <= mag_opnd;
`endif
                    // Multiply keeps the multiplier in acc_lo, the multiplicand in opnd
                    if (is_div) begin
                        acc_lo <= mag_lo;
                        opnd   <= mag_opnd;
                    end else begin
                        acc_lo <= mag_opnd;
                        opnd   <= mag_lo;
                    end
                    if (div_zero) begin
                        done <= 1'b1;
                        div0 <= 1'b1;
                    end
                end
                CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 1'b1;
`ifdef MULDIV_EARLY_TERM_EN
                    mplr   <= mplr >> 1;
`endif
                end
                FIX: begin
                    done <= 1'b1;
                    if (is_div) begin
                        hi <= neg_hi ? -acc_hi : acc_hi;
                        lo <= neg_lo ? -acc_lo : acc_lo;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32); honours MULDIV_EARLY_TERM_EN.
module tb_muldiv_unit;

    localparam int unsigned WIDTH = 32;
`ifdef MULDIV_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycles from the accepting edge to done for a non-zero-divisor op
    function automatic int exp_lat(input logic [1:0] o, input logic [WIDTH-1:0] y);
        int k;
        logic [WIDTH-1:0] m;
        m = (o == 2'b00 && y[WIDTH-1]) ? -y : y;
        k = 1;
        for (int i = 0; i < int'(WIDTH); i++) if (m[i]) k = i + 1;
        if (EARLY && !o[1]) return k + 2;
        return int'(WIDTH) + 2;
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clock); #1;
            n++;
            if (done) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input int lat, input logic [WIDTH-1:0] eh,
                          input logic [WIDTH-1:0] el, input logic ed);
        int n;
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clock); #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        check({tag, "_busy_on"}, 64'(busy), 64'(1));
        check({tag, "_div0_clr"}, 64'(div0), 64'(0));
        wait_done(n);
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        check({tag, "_div0"}, 64'(div0), 64'(ed));
        check({tag, "_busy_off"}, 64'(busy), 64'(0));
        @(posedge clock); #1;
        check({tag, "_pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        int n;
        int done_cnt;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_div0", 64'(div0), 64'(0));
        check("rst_hilo", {hi, lo}, 64'(0));
        @(negedge clock); reset = 1'b0;

        run_op("mult_neg3x5", 2'b00, 32'hFFFFFFFD, 32'd5, exp_lat(2'b00, 32'd5),
               32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_op("mult_neg5xneg7", 2'b00, 32'hFFFFFFFB, 32'hFFFFFFF9, exp_lat(2'b00, 32'hFFFFFFF9),
               32'h0, 32'h23, 1'b0);
        run_op("div_7_neg2", 2'b10, 32'd7, 32'hFFFFFFFE, exp_lat(2'b10, 32'hFFFFFFFE),
               32'h1, 32'hFFFFFFFD, 1'b0);
        run_op("div_neg7_2", 2'b10, 32'hFFFFFFF9, 32'd2, exp_lat(2'b10, 32'd2),
               32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("divu_max_2", 2'b11, 32'hFFFFFFFF, 32'd2, exp_lat(2'b11, 32'd2),
               32'h1, 32'h7FFFFFFF, 1'b0);
        run_op("divu_prior", 2'b11, 32'hAAAABBBB, 32'h00010000, exp_lat(2'b11, 32'h00010000),
               32'h0000BBBB, 32'h0000AAAA, 1'b0);
        // Divide by zero: done one edge after acceptance, hi/lo untouched
        run_op("div_by0", 2'b10, 32'h12345678, 32'h0, 1, 32'h0000BBBB, 32'h0000AAAA, 1'b1);
        run_op("div_min_neg1", 2'b10, 32'h80000000, 32'hFFFFFFFF, exp_lat(2'b10, 32'hFFFFFFFF),
               32'h0, 32'h80000000, 1'b0);
        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, exp_lat(2'b01, 32'hFFFFFFFF),
               32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("multu_100x3", 2'b01, 32'd100, 32'd3, exp_lat(2'b01, 32'd3), 32'h0, 32'd300, 1'b0);
        run_op("multu_x0", 2'b01, 32'd100, 32'd0, exp_lat(2'b01, 32'd0), 32'h0, 32'h0, 1'b0);
        run_op("divu_100_3", 2'b11, 32'd100, 32'd3, exp_lat(2'b11, 32'd3), 32'h1, 32'd33, 1'b0);

        // start pulsed while busy must be ignored
        @(negedge clock); start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
        @(posedge clock); #1;
        n = 0;
        while (n < 200) begin
            @(negedge clock);
            start = (n == 9); op = 2'b10; a = 32'd9; b = 32'd2;
            @(posedge clock); #1;
            n++;
            if (done) break;
        end
        start = 1'b0;
        check("ignore_lat", 64'(n), 64'(exp_lat(2'b00, 32'd7)));
        check("ignore_hilo", {hi, lo}, 64'd42);
        @(posedge clock); #1;
        check("ignore_idle", 64'(busy), 64'(0));

        // Asynchronous reset mid-operation
        @(negedge clock); start = 1'b1; op = 2'b01; a = 32'd5; b = 32'h00010001;
        @(posedge clock); #1; start = 1'b0;
        repeat (5) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_hilo", {hi, lo}, 64'(0));
        @(negedge clock); reset = 1'b0;
        done_cnt = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done || busy) done_cnt++;
        end
        check("midrst_quiet", 64'(done_cnt), 64'(0));

        // start held high across done: second op accepted in the first IDLE cycle
        @(negedge clock); start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
        @(posedge clock); #1;
        wait_done(n);
        check("held_lat1", 64'(n), 64'(exp_lat(2'b01, 32'd3)));
        check("held_lo1", 64'(lo), 64'd6);
        a = 32'd4;
        @(posedge clock); #1;
        check("held_reaccept", 64'(busy), 64'(1));
        start = 1'b0;
        wait_done(n);
        check("held_lat2", 64'(n), 64'(exp_lat(2'b01, 32'd3)));
        check("held_lo2", 64'(lo), 64'd12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
